// File: rtl/baser_pkg.sv
// Shared BASE-R 66b definitions: block types, sync headers, lock states and
// the per-block classification record used by the lane checkers.
package baser_pkg;

  localparam logic [7:0] BT_IDLE  = 8'h1E;
  localparam logic [7:0] BT_START = 8'h78;
  localparam logic [7:0] BT_OSET  = 8'h4B;
  localparam logic [7:0] BT_TERM0 = 8'h87;
  localparam logic [7:0] BT_TERM1 = 8'h99;
  localparam logic [7:0] BT_TERM2 = 8'hAA;
  localparam logic [7:0] BT_TERM3 = 8'hB4;
  localparam logic [7:0] BT_TERM4 = 8'hCC;
  localparam logic [7:0] BT_TERM5 = 8'hD2;
  localparam logic [7:0] BT_TERM6 = 8'hE1;
  localparam logic [7:0] BT_TERM7 = 8'hFF;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int unsigned NUM_CNT       = 7;
  localparam int unsigned CNT_BLOCK     = 0;
  localparam int unsigned CNT_DATA      = 1;
  localparam int unsigned CNT_CTRL      = 2;
  localparam int unsigned CNT_INV_BLOCK = 3;
  localparam int unsigned CNT_INV_PAT   = 4;
  localparam int unsigned CNT_INV_FMT   = 5;
  localparam int unsigned CNT_INV_SH    = 6;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_e;

  typedef struct packed {
    logic is_data;
    logic is_ctrl;
    logic sh_err;
    logic fmt_err;
    logic pat_err;
  } blk_class_t;

  // Number of data octets in a Terminate block; bit 3 set means "not a Terminate".
  function automatic logic [3:0] term_len(input logic [7:0] bt);
    case (bt)
      BT_TERM0: return 4'd0;
      BT_TERM1: return 4'd1;
      BT_TERM2: return 4'd2;
      BT_TERM3: return 4'd3;
      BT_TERM4: return 4'd4;
      BT_TERM5: return 4'd5;
      BT_TERM6: return 4'd6;
      BT_TERM7: return 4'd7;
      default:  return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/baser_66b_lane_checker.sv
// One 66b lane: block classification (stage 1), then saturating statistics
// counters and the sync-header lock FSM (stage 2).
module baser_66b_lane_checker
  import baser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned HDR_WIDTH         = 2,
  parameter int unsigned FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [6:0]  CTRL_CHAR_PATTERN = 7'h1E,
  parameter logic [3:0]  OSET_CHAR_PATTERN = 4'hB,
  parameter int unsigned LOCK_GOOD_CNT     = 64,
  parameter int unsigned BER_WINDOW        = 64,
  parameter int unsigned BAD_SH_LIMIT      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [FRAME_WIDTH-1:0] frame_i,
  input  logic                   cnt_clear_i,
  output logic                   block_lock_o,
  output logic                   lock_lost_o,
  output logic [CNT_WIDTH-1:0]   block_count_o,
  output logic [CNT_WIDTH-1:0]   data_count_o,
  output logic [CNT_WIDTH-1:0]   ctrl_count_o,
  output logic [CNT_WIDTH-1:0]   inv_block_count_o,
  output logic [CNT_WIDTH-1:0]   inv_pattern_count_o,
  output logic [CNT_WIDTH-1:0]   inv_format_count_o,
  output logic [CNT_WIDTH-1:0]   inv_sh_count_o
);

  localparam int unsigned BODY_W = DATA_WIDTH - 8;
  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD_CNT + 1);
  localparam int unsigned WIN_W  = $clog2(BER_WINDOW + 1);
  localparam int unsigned BAD_W  = $clog2(BAD_SH_LIMIT + 1);

  function automatic logic [BODY_W-1:0] idle_exp();
    logic [BODY_W-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < 8; i++) e[7*i +: 7] = CTRL_CHAR_PATTERN;
    return e;
  endfunction

  function automatic logic [BODY_W-1:0] start_exp();
    logic [BODY_W-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < 7; i++) e[8*i +: 8] = DATA_CHAR_PATTERN;
    return e;
  endfunction

  function automatic logic [BODY_W-1:0] oset_exp();
    logic [BODY_W-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < 3; i++) e[8*i +: 8] = DATA_CHAR_PATTERN;
    e[27:24] = OSET_CHAR_PATTERN;
    return e;
  endfunction

  // Tn body: n data octets, (7-n) zero pad bits, then (7-n) control chars.
  function automatic logic [BODY_W-1:0] term_exp(input int unsigned n);
    logic [BODY_W-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < 7; i++)
      if (i < n) e[8*i +: 8] = DATA_CHAR_PATTERN;
    for (int unsigned j = 0; j < 7; j++)
      if (j + n < 7) e[7*n + 7 + 7*j +: 7] = CTRL_CHAR_PATTERN;
    return e;
  endfunction

  localparam logic [DATA_WIDTH-1:0] DATA_EXP  = {(DATA_WIDTH/8){DATA_CHAR_PATTERN}};
  localparam logic [BODY_W-1:0]     IDLE_EXP  = idle_exp();
  localparam logic [BODY_W-1:0]     START_EXP = start_exp();
  localparam logic [BODY_W-1:0]     OSET_EXP  = oset_exp();
  localparam logic [BODY_W-1:0]     TERM_EXP [8] = '{term_exp(0), term_exp(1),
    term_exp(2), term_exp(3), term_exp(4), term_exp(5), term_exp(6), term_exp(7)};

  logic [HDR_WIDTH-1:0]  hdr;
  logic [DATA_WIDTH-1:0] payload;
  logic [7:0]            blk_type;
  logic [BODY_W-1:0]     body;
  logic [BODY_W-1:0]     body_exp;
  logic [3:0]            tlen;
  logic                  fmt_ok;
  blk_class_t            cls_d, cls_q;
  logic                  valid_q;

  assign hdr      = frame_i[HDR_WIDTH-1:0];
  assign payload  = frame_i[FRAME_WIDTH-1 -: DATA_WIDTH];
  assign blk_type = payload[7:0];
  assign body     = payload[DATA_WIDTH-1:8];

  always_comb begin
    body_exp = '0;
    fmt_ok   = 1'b1;
    tlen     = term_len(blk_type);
    if (blk_type == BT_IDLE)       body_exp = IDLE_EXP;
    else if (blk_type == BT_START) body_exp = START_EXP;
    else if (blk_type == BT_OSET)  body_exp = OSET_EXP;
    else if (!tlen[3])             body_exp = TERM_EXP[tlen[2:0]];
    else                           fmt_ok = 1'b0;

    // Error priority sh > format > pattern keeps the error flags one-hot.
    cls_d = '0;
    if (hdr == SH_DATA) begin
      cls_d.pat_err = (payload != DATA_EXP);
      cls_d.is_data = (payload == DATA_EXP);
    end else if (hdr == SH_CTRL) begin
      if (!fmt_ok)                cls_d.fmt_err = 1'b1;
      else if (body != body_exp)  cls_d.pat_err = 1'b1;
      else                        cls_d.is_ctrl = 1'b1;
    end else begin
      cls_d.sh_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cls_q   <= '0;
    end else begin
      valid_q <= valid_i;
      cls_q   <= cls_d;
    end
  end

  logic [NUM_CNT-1:0]   inc;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];

  always_comb begin
    inc                = '0;
    inc[CNT_BLOCK]     = 1'b1;
    inc[CNT_DATA]      = cls_q.is_data;
    inc[CNT_CTRL]      = cls_q.is_ctrl;
    inc[CNT_INV_BLOCK] = cls_q.sh_err | cls_q.fmt_err | cls_q.pat_err;
    inc[CNT_INV_PAT]   = cls_q.pat_err;
    inc[CNT_INV_FMT]   = cls_q.fmt_err;
    inc[CNT_INV_SH]    = cls_q.sh_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CNT; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CNT; c++) begin
        if (cnt_clear_i)
          cnt_q[c] <= '0;
        else if (valid_q && inc[c] && (cnt_q[c] != '1))
          cnt_q[c] <= cnt_q[c] + 1'b1;
      end
    end
  end

  lock_state_e       state_q;
  logic [GOOD_W-1:0] good_q;
  logic [WIN_W-1:0]  win_q;
  logic [BAD_W-1:0]  bad_q;
  logic              lock_q;
  logic              lost_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      lock_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      if (valid_q) begin
        case (state_q)
          HUNT: begin
            if (cls_q.sh_err) begin
              good_q <= '0;
            end else if (good_q == GOOD_W'(LOCK_GOOD_CNT - 1)) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
              good_q  <= '0;
              win_q   <= '0;
              bad_q   <= '0;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end
          LOCKED: begin
            // Loss of lock wins over the window wrap on the same block.
            if (cls_q.sh_err && (bad_q == BAD_W'(BAD_SH_LIMIT - 1))) begin
              state_q <= HUNT;
              lock_q  <= 1'b0;
              lost_q  <= 1'b1;
              good_q  <= '0;
            end else if (win_q == WIN_W'(BER_WINDOW - 1)) begin
              win_q <= '0;
              bad_q <= '0;
            end else begin
              win_q <= win_q + 1'b1;
              bad_q <= bad_q + BAD_W'(cls_q.sh_err);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign block_lock_o        = lock_q;
  assign lock_lost_o         = lost_q;
  assign block_count_o       = cnt_q[CNT_BLOCK];
  assign data_count_o        = cnt_q[CNT_DATA];
  assign ctrl_count_o        = cnt_q[CNT_CTRL];
  assign inv_block_count_o   = cnt_q[CNT_INV_BLOCK];
  assign inv_pattern_count_o = cnt_q[CNT_INV_PAT];
  assign inv_format_count_o  = cnt_q[CNT_INV_FMT];
  assign inv_sh_count_o      = cnt_q[CNT_INV_SH];

endmodule

// File: rtl/baser_66b_multilane_checker.sv
// NUM_LANES independent 66b lane checkers sharing one clock; the top only
// slices the lane buses and delays i_valid.
module baser_66b_multilane_checker
  import baser_pkg::*;
#(
  parameter int unsigned NUM_LANES         = 4,
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned HDR_WIDTH         = 2,
  parameter int unsigned FRAME_WIDTH       = DATA_WIDTH + HDR_WIDTH,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [6:0]  CTRL_CHAR_PATTERN = 7'h1E,
  parameter logic [3:0]  OSET_CHAR_PATTERN = 4'hB,
  parameter int unsigned LOCK_GOOD_CNT     = 64,
  parameter int unsigned BER_WINDOW        = 64,
  parameter int unsigned BAD_SH_LIMIT      = 16
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  input  logic [NUM_LANES*FRAME_WIDTH-1:0] i_rx_coded,
  input  logic                             i_cnt_clear,
  output logic                             o_valid,
  output logic [NUM_LANES-1:0]             o_block_lock,
  output logic [NUM_LANES-1:0]             o_lock_lost,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_block_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_data_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_ctrl_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_inv_block_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_inv_pattern_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_inv_format_count,
  output logic [NUM_LANES*CNT_WIDTH-1:0]   o_inv_sh_count
);

  logic valid_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) valid_q <= 1'b0;
    else          valid_q <= i_valid;
  end

  assign o_valid = valid_q;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    baser_66b_lane_checker #(
      .DATA_WIDTH        (DATA_WIDTH),
      .HDR_WIDTH         (HDR_WIDTH),
      .FRAME_WIDTH       (FRAME_WIDTH),
      .CNT_WIDTH         (CNT_WIDTH),
      .DATA_CHAR_PATTERN (DATA_CHAR_PATTERN),
      .CTRL_CHAR_PATTERN (CTRL_CHAR_PATTERN),
      .OSET_CHAR_PATTERN (OSET_CHAR_PATTERN),
      .LOCK_GOOD_CNT     (LOCK_GOOD_CNT),
      .BER_WINDOW        (BER_WINDOW),
      .BAD_SH_LIMIT      (BAD_SH_LIMIT)
    ) u_lane (
      .clk                 (clk),
      .rst_n               (i_rst_n),
      .valid_i             (i_valid),
      .frame_i             (i_rx_coded[k*FRAME_WIDTH +: FRAME_WIDTH]),
      .cnt_clear_i         (i_cnt_clear),
      .block_lock_o        (o_block_lock[k]),
      .lock_lost_o         (o_lock_lost[k]),
      .block_count_o       (o_block_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .data_count_o        (o_data_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .ctrl_count_o        (o_ctrl_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .inv_block_count_o   (o_inv_block_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .inv_pattern_count_o (o_inv_pattern_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .inv_format_count_o  (o_inv_format_count[k*CNT_WIDTH +: CNT_WIDTH]),
      .inv_sh_count_o      (o_inv_sh_count[k*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_baser_66b_multilane_checker.sv
// Directed bench: a per-lane reference model pushes expected counter/lock
// snapshots per block; a negedge monitor pops and compares them.
module tb_baser_66b_multilane_checker;

  localparam int NL = 4;
  localparam int CW = 32;

  typedef enum {C_DATA, C_CTRL, C_PAT, C_FMT, C_SH} cat_e;

  typedef struct packed {
    logic [NL-1:0]            lock;
    logic [NL-1:0]            lost;
    logic [6:0][NL*CW-1:0]    cnt;
  } exp_t;

  localparam logic [65:0] F_DATA    = {{8{8'hAA}}, 2'b01};
  localparam logic [65:0] F_IDLE    = {{8{7'h1E}}, 8'h1E, 2'b10};
  localparam logic [65:0] F_START   = {{7{8'hAA}}, 8'h78, 2'b10};
  localparam logic [65:0] F_T7      = {{7{8'hAA}}, 8'hFF, 2'b10};
  localparam logic [65:0] F_T0      = {{7{7'h1E}}, 7'h00, 8'h87, 2'b10};
  localparam logic [65:0] F_T3      = {{4{7'h1E}}, 4'h0, {3{8'hAA}}, 8'hB4, 2'b10};
  localparam logic [65:0] F_OSET    = {28'h0, 4'hB, {3{8'hAA}}, 8'h4B, 2'b10};
  localparam logic [65:0] F_OSETBAD = {28'h1, 4'hB, {3{8'hAA}}, 8'h4B, 2'b10};
  localparam logic [65:0] F_BADTYPE = {{7{8'hAA}}, 8'h86, 2'b10};
  localparam logic [65:0] F_T7BAD   = {8'hAB, {6{8'hAA}}, 8'hFF, 2'b10};
  localparam logic [65:0] F_SH11    = {{8{8'hAA}}, 2'b11};
  localparam logic [65:0] F_SH00    = {{8{8'hAA}}, 2'b00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rst_n, i_valid, i_cnt_clear;
  logic [NL*66-1:0]   i_rx_coded;
  logic               o_valid;
  logic [NL-1:0]      o_block_lock, o_lock_lost;
  logic [NL*CW-1:0]   o_block_count, o_data_count, o_ctrl_count, o_inv_block_count;
  logic [NL*CW-1:0]   o_inv_pattern_count, o_inv_format_count, o_inv_sh_count;

  logic               v4, clr4;
  logic [65:0]        rx4;
  logic               o4_valid, o4_lock, o4_lost;
  logic [3:0]         o4_blk, o4_data, o4_ctrl, o4_inv, o4_pat, o4_fmt, o4_sh;

  baser_66b_multilane_checker #(.NUM_LANES(NL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_rx_coded(i_rx_coded),
    .i_cnt_clear(i_cnt_clear), .o_valid(o_valid), .o_block_lock(o_block_lock),
    .o_lock_lost(o_lock_lost), .o_block_count(o_block_count), .o_data_count(o_data_count),
    .o_ctrl_count(o_ctrl_count), .o_inv_block_count(o_inv_block_count),
    .o_inv_pattern_count(o_inv_pattern_count), .o_inv_format_count(o_inv_format_count),
    .o_inv_sh_count(o_inv_sh_count));

  baser_66b_multilane_checker #(.NUM_LANES(1), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(v4), .i_rx_coded(rx4),
    .i_cnt_clear(clr4), .o_valid(o4_valid), .o_block_lock(o4_lock),
    .o_lock_lost(o4_lost), .o_block_count(o4_blk), .o_data_count(o4_data),
    .o_ctrl_count(o4_ctrl), .o_inv_block_count(o4_inv),
    .o_inv_pattern_count(o4_pat), .o_inv_format_count(o4_fmt),
    .o_inv_sh_count(o4_sh));

  int n_assert = 0;
  int n_fail   = 0;
  int lost0_seen = 0;
  exp_t q[$];
  bit chk_pend = 1'b0;

  int unsigned m_cnt [NL][7];
  bit          m_lock[NL];
  int unsigned m_good[NL], m_win[NL], m_bad[NL];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [NL*CW-1:0] act_cnt(input int c);
    case (c)
      0: return o_block_count;
      1: return o_data_count;
      2: return o_ctrl_count;
      3: return o_inv_block_count;
      4: return o_inv_pattern_count;
      5: return o_inv_format_count;
      default: return o_inv_sh_count;
    endcase
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      for (int c = 0; c < 7; c++) m_cnt[l][c] = 0;
      m_lock[l] = 1'b0; m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0;
    end
  endtask

  task automatic model_blk(input int l, input cat_e c, output bit lost);
    lost = 1'b0;
    m_cnt[l][0]++;
    case (c)
      C_DATA: m_cnt[l][1]++;
      C_CTRL: m_cnt[l][2]++;
      C_PAT:  begin m_cnt[l][3]++; m_cnt[l][4]++; end
      C_FMT:  begin m_cnt[l][3]++; m_cnt[l][5]++; end
      default: begin m_cnt[l][3]++; m_cnt[l][6]++; end
    endcase
    if (!m_lock[l]) begin
      if (c == C_SH) m_good[l] = 0;
      else begin
        m_good[l]++;
        if (m_good[l] == 64) begin m_lock[l] = 1'b1; m_win[l] = 0; m_bad[l] = 0; end
      end
    end else begin
      m_win[l]++;
      if (c == C_SH) m_bad[l]++;
      if (m_bad[l] == 16) begin m_lock[l] = 1'b0; lost = 1'b1; m_good[l] = 0; end
      else if (m_win[l] == 64) begin m_win[l] = 0; m_bad[l] = 0; end
    end
  endtask

  // Lane `lane` gets frame f of category c; all other lanes get a good data block.
  task automatic send(input int lane, input logic [65:0] f, input cat_e c);
    exp_t e;
    bit lost;
    e = '0;
    for (int l = 0; l < NL; l++) begin
      i_rx_coded[l*66 +: 66] = (l == lane) ? f : F_DATA;
      model_blk(l, (l == lane) ? c : C_DATA, lost);
      e.lock[l] = m_lock[l];
      e.lost[l] = lost;
      for (int k = 0; k < 7; k++) e.cnt[k][l*CW +: CW] = m_cnt[l][k];
    end
    i_valid = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_lock"}, o_block_lock, 0);
    chk({tag, "_lost"}, o_lock_lost, 0);
    for (int c = 0; c < 7; c++) chk($sformatf("%s_cnt%0d", tag, c), act_cnt(c), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_pend) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_lock", o_block_lock, e.lock);
        chk("sb_lost", o_lock_lost, e.lost);
        for (int c = 0; c < 7; c++) chk($sformatf("sb_cnt%0d", c), act_cnt(c), e.cnt[c]);
      end
    end
    chk_pend = o_valid;
    if (o_lock_lost[0]) lost0_seen++;
  end

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_cnt_clear = 1'b0; i_rx_coded = '0;
    v4 = 1'b0; clr4 = 1'b0; rx4 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 70; i++) send(-1, F_DATA, C_DATA);
    idle(3);
    chk("lock_all", o_block_lock, 4'hF);
    chk("blk_70", o_block_count, {4{32'd70}});
    chk("data_70", o_data_count, {4{32'd70}});
    chk("inv_70", o_inv_block_count, 0);

    send(2, F_IDLE, C_CTRL);
    send(2, F_START, C_CTRL);
    send(2, F_T7, C_CTRL);
    send(2, F_T0, C_CTRL);
    idle(3);
    chk("l2_ctrl", o_ctrl_count[2*CW +: CW], 4);
    chk("l2_inv", o_inv_block_count[2*CW +: CW], 0);

    send(1, F_BADTYPE, C_FMT);
    send(1, F_T7BAD, C_PAT);
    idle(3);
    chk("l1_fmt", o_inv_format_count[1*CW +: CW], 1);
    chk("l1_pat", o_inv_pattern_count[1*CW +: CW], 1);
    chk("l1_inv", o_inv_block_count[1*CW +: CW], 2);

    for (int i = 0; i < 16; i++) send(0, F_SH11, C_SH);
    idle(3);
    chk("l0_lost_pulses", lost0_seen, 1);
    chk("l0_unlocked", o_block_lock, 4'hE);
    chk("l0_sh", o_inv_sh_count[0*CW +: CW], 16);

    send(2, F_T3, C_CTRL);
    send(2, F_OSET, C_CTRL);
    send(2, F_OSETBAD, C_PAT);
    send(1, F_SH00, C_SH);

    for (int i = 0; i < 192; i++) begin
      if ((i % 64) < 15) send(3, F_SH11, C_SH);
      else               send(3, F_DATA, C_DATA);
      if (i % 50 == 49) idle(2);
    end
    idle(3);
    chk("l3_locked", o_block_lock[3], 1);
    chk("l0_relocked", o_block_lock[0], 1);
    chk("l3_sh", o_inv_sh_count[3*CW +: CW], 45);
    chk("sb_drain", q.size(), 0);

    for (int i = 0; i < 20; i++) begin
      v4 = 1'b1; rx4 = F_DATA;
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_blk", o4_blk, 4'hF);
    chk("sat_data", o4_data, 4'hF);
    chk("sat_inv", o4_inv, 0);
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
    chk("clr_blk", o4_blk, 0);
    chk("clr_data", o4_data, 0);
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_clr_blk", o4_blk, 1);

    for (int l = 0; l < NL; l++) i_rx_coded[l*66 +: 66] = F_DATA;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    chk("mid_reset_dut4", o4_blk, 0);
    model_reset();
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    send(-1, F_DATA, C_DATA);
    send(-1, F_DATA, C_DATA);
    idle(3);
    chk("post_reset_blk", o_block_count, {4{32'd2}});
    chk("sb_final", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/baser_66b_multilane_checker.md
Name: baser_66b_multilane_checker

Overview:
- Parametrised successor to the single-stream 66b checker. Checks NUM_LANES independent 66b streams in parallel.
- Per lane: classifies each block (data, control, invalid), checks fixed character patterns, runs a sync-header block-lock state machine and keeps saturating statistics counters.
- Sits after the 257b-to-66b transcoder checker, or directly on a multi-lane PCS receive bus, in the BASE-R verification agents.

Parameters:
- NUM_LANES, 4, number of 66b lanes checked in parallel (1..16).
- DATA_WIDTH, 64, payload bits per block.
- HDR_WIDTH, 2, sync header bits.
- FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH, block width.
- CNT_WIDTH, 32, width of each statistics counter.
- DATA_CHAR_PATTERN, 8'hAA, required value of every data octet.
- CTRL_CHAR_PATTERN, 7'h1E, required value of every 7-bit control character.
- OSET_CHAR_PATTERN, 4'hB, required O-code in ordered-set blocks.
- LOCK_GOOD_CNT, 64, consecutive good headers needed to acquire lock.
- BER_WINDOW, 64, blocks per bad-header window while locked.
- BAD_SH_LIMIT, 16, bad headers within one window that force loss of lock.

Ports:
- clk  in  1  single clock; one 66b block per lane per cycle when i_valid is high.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  all lanes carry a block this cycle.
- i_rx_coded  in  NUM_LANES*FRAME_WIDTH  lane k at [k*FRAME_WIDTH +: FRAME_WIDTH]; header at bits [1:0], block type at [9:2].
- i_cnt_clear  in  1  synchronous clear of all counters.
- o_valid  out  1  i_valid delayed by 1 cycle.
- o_block_lock  out  NUM_LANES  per-lane lock status.
- o_lock_lost  out  NUM_LANES  one-cycle pulse on LOCKED->HUNT.
- o_block_count, o_data_count, o_ctrl_count, o_inv_block_count, o_inv_pattern_count, o_inv_format_count, o_inv_sh_count  out  NUM_LANES*CNT_WIDTH each  per-lane counters, lane k at [k*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- Reset: all outputs and counters 0; every lane FSM in HUNT with good count 0.
- Pipeline: stage 1 registers the per-lane classification; stage 2 updates counters and FSM. o_valid, counters and lock therefore reflect a block 1 cycle after o_valid rises for it (2 edges after input).
- When i_valid=0: no counter, FSM or window change.
- Header 2'b01 = data. All 8 octets must equal DATA_CHAR_PATTERN, else pattern error.
- Header 2'b10 = control. Block type must be one of 1E,78,4B,87,99,AA,B4,CC,D2,E1,FF, else format error.
- Control patterns:
  - 1E: eight 7-bit chars equal CTRL_CHAR_PATTERN.
  - 78: seven octets equal DATA_CHAR_PATTERN.
  - 4B: three data octets equal DATA_CHAR_PATTERN, O-code equals OSET_CHAR_PATTERN, remaining 28 bits zero.
  - Terminate Tn (n = 0..7 for 87..FF): n data octets, then (7-n) zero pad bits, then (7-n) control chars equal CTRL_CHAR_PATTERN.
- Header 2'b00 or 2'b11: sync-header error. Payload is not checked.
- Counters, per lane:
  - block_count increments on every valid block.
  - data_count / ctrl_count increment only on fully valid blocks of that kind.
  - inv_block_count increments once per block with any error.
  - Each specific error counter increments; errors are mutually exclusive in priority sh > format > pattern.
- Counters saturate at all-ones. i_cnt_clear has priority over a simultaneous increment and forces the value to 0.
- Lock FSM, per lane, states HUNT and LOCKED:
  - HUNT: a good header increments good_cnt; a bad header clears it. good_cnt reaching LOCK_GOOD_CNT -> LOCKED, with window and bad counts cleared.
  - LOCKED: blk_in_win and bad_cnt advance per block.
  - If bad_cnt reaches BAD_SH_LIMIT -> HUNT, o_lock_lost pulses, good_cnt = 0.
  - Else, when blk_in_win reaches BER_WINDOW, both counts clear and the lane stays LOCKED.
  - A bad header on the window's last block that hits the limit takes the loss of lock.
- Counting is independent of lock state.
- Lanes are fully independent; no cross-lane deskew.
- Reset asserted mid-stream returns everything to reset values immediately; pipeline contents are discarded.

Decomposition:
- Shared package baser_pkg:
  - block-type constants (BT_IDLE=8'h1E, BT_START=8'h78, BT_OSET=8'h4B, BT_TERM0..7);
  - sync header constants SH_DATA=2'b01, SH_CTRL=2'b10;
  - lock state enum {HUNT, LOCKED};
  - classification struct {is_data, is_ctrl, sh_err, fmt_err, pat_err}.
- One sub-module, baser_66b_lane_checker: classifier, lock FSM and counters for one lane, instantiated NUM_LANES times in a generate loop. The top handles only slicing and o_valid.

Test Plan:
- Reset release, then 70 valid data blocks (01, all AA) on all 4 lanes:
  - o_block_lock rises after block 64;
  - each lane reads block_count=70, data_count=70, no errors.
- Lane 2 sends 1E idle, 78 start, FF term, 87 with 7'h0 pad plus 7×1E, while other lanes send data:
  - lane 2 ctrl_count=4, inv=0.
- Lane 1 sends type 8'h86, then 0xFF block with one octet 8'hAB:
  - inv_format_count=1, inv_pattern_count=1, inv_block_count=2.
- Locked lane 0 receives 16 headers 2'b11 within one 64-block window:
  - o_lock_lost pulses once;
  - o_block_lock[0]=0; inv_sh_count=16; other lanes stay locked.
- Locked lane 3 receives 15 bad headers per window over 3 windows:
  - lane stays locked.
- Counters preloaded near saturation (CNT_WIDTH=4 build), 20 blocks sent:
  - block_count holds 15;
  - i_cnt_clear asserted on an increment cycle yields 0.
